// File: rtl/b08_host_pkg.sv
// Shared types and widths for the b08 host driver.
// Purely declarative: no latency, no flow control.
package b08_host_pkg;
  localparam int B08_I_W   = 8;
  localparam int B08_O_W   = 4;
  localparam int B08_RES_W = B08_I_W + B08_O_W;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    CAPTURE,
    EMIT
  } b08_host_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/b08_host_timer.sv
// Loadable down-counter that saturates at zero; load wins over counting.
// Zero flag is combinational from the count register; no flow control.
module b08_host_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/b08_host.sv
// Drives one byte at a time into the b08 core and returns {byte, O}; result valid START_HOLD+WAIT_CYCLES+2 cycles after accept.
// Input is refused while busy; the result is held stable until RES_READY.
module b08_host
  import b08_host_pkg::*;
#(
  parameter int START_HOLD  = 2,
  parameter int WAIT_CYCLES = 12
) (
  input  logic                 CLOCK,
  input  logic                 RESET_N,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [B08_I_W-1:0]   IN_DATA,
  output logic                 START,
  output logic [B08_I_W-1:0]   I,
  input  logic [B08_O_W-1:0]   O,
  output logic                 RES_VALID,
  input  logic                 RES_READY,
  output logic [B08_RES_W-1:0] RES_DATA,
  output logic                 BUSY,
  output logic [7:0]           RUN_COUNT
);
  localparam int TW = $clog2(max_int(START_HOLD, WAIT_CYCLES) + 1);

  b08_host_state_t      r_state;
  b08_host_state_t      w_next;
  logic [B08_I_W-1:0]   r_data;
  logic [B08_RES_W-1:0] r_res;
  logic                 r_start;
  logic [7:0]           r_run_cnt;
  logic                 w_accept;
  logic                 w_tmr_load;
  logic [TW-1:0]        w_tmr_val;
  logic                 w_tmr_zero;

  b08_host_timer #(.W(TW)) u_timer (
    .clk     (CLOCK),
    .rst_n   (RESET_N),
    .i_load  (w_tmr_load),
    .i_value (w_tmr_val),
    .o_zero  (w_tmr_zero)
  );

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (IN_VALID)   w_next = LAUNCH;
      LAUNCH:  if (w_tmr_zero) w_next = WAIT;
      WAIT:    if (w_tmr_zero) w_next = CAPTURE;
      CAPTURE:                 w_next = EMIT;
      EMIT:    if (RES_READY)  w_next = IDLE;
      default:                 w_next = IDLE;
    endcase
  end

  always_comb begin
    w_accept   = 1'b0;
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    case (r_state)
      IDLE: begin
        if (IN_VALID) begin
          w_accept   = 1'b1;
          w_tmr_load = 1'b1;
          w_tmr_val  = TW'(START_HOLD - 1);
        end
      end
      LAUNCH: begin
        if (w_tmr_zero) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = TW'(WAIT_CYCLES - 1);
        end
      end
      default: ;
    endcase
  end

  // START is registered from the next state so it leaves a flop and never glitches.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_start   <= 1'b0;
      r_data    <= '0;
      r_res     <= '0;
      r_run_cnt <= '0;
    end else begin
      r_start <= (w_next == LAUNCH);
      if (w_accept) begin
        r_data <= IN_DATA;
      end
      if (r_state == CAPTURE) begin
        r_res <= {r_data, O};
      end
      if (r_state == EMIT && RES_READY) begin
        r_run_cnt <= r_run_cnt + 8'd1;
      end
    end
  end

  assign IN_READY  = (r_state == IDLE);
  assign BUSY      = (r_state != IDLE);
  assign RES_VALID = (r_state == EMIT);
  assign START     = r_start;
  assign I         = r_data;
  assign RES_DATA  = r_res;
  assign RUN_COUNT = r_run_cnt;
endmodule

// File: tb/tb_b08_host.sv
// Randomized directed bench for b08_host: default instance plus a START_HOLD=1/WAIT_CYCLES=1 instance.
// A behavioural b08 core supplies O; expected results come from an inclusion-count reference.
module tb_b08_host;
  logic CLOCK = 1'b0;
  logic RESET_N;
  always #5 CLOCK = ~CLOCK;

  logic        in_valid, in_ready, start, res_valid, res_ready, busy;
  logic [7:0]  in_data, i_bus, run_count;
  logic [3:0]  o_bus;
  logic [11:0] res_data;

  logic        c_in_valid, c_in_ready, c_start, c_res_valid, c_res_ready, c_busy;
  logic [7:0]  c_in_data, c_i, c_run_count;
  logic [3:0]  c_o;
  logic [11:0] c_res_data;

  b08_host dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .IN_VALID(in_valid), .IN_READY(in_ready),
    .IN_DATA(in_data), .START(start), .I(i_bus), .O(o_bus), .RES_VALID(res_valid),
    .RES_READY(res_ready), .RES_DATA(res_data), .BUSY(busy), .RUN_COUNT(run_count)
  );

  b08_host #(.START_HOLD(1), .WAIT_CYCLES(1)) dut_c (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .IN_VALID(c_in_valid), .IN_READY(c_in_ready),
    .IN_DATA(c_in_data), .START(c_start), .I(c_i), .O(c_o), .RES_VALID(c_res_valid),
    .RES_READY(c_res_ready), .RES_DATA(c_res_data), .BUSY(c_busy), .RUN_COUNT(c_run_count)
  );

  // b08 core behaviour: O counts how many ROM patterns are contained in the input byte.
  logic [7:0] rom [8] = '{8'h01, 8'h03, 8'h10, 8'h81, 8'h24, 8'h0F, 8'hC0, 8'h5A};

  function automatic logic [3:0] incl(input logic [7:0] b);
    int n = 0;
    for (int k = 0; k < 8; k++) if ((b & rom[k]) == rom[k]) n++;
    return 4'(n);
  endfunction

  function automatic logic [11:0] exp_res(input logic [7:0] b);
    return {b, incl(b)};
  endfunction

  // Core output is junk until 9 cycles after START falls, then the real answer.
  int core_cnt = 50;
  always @(posedge CLOCK) begin
    if (start) core_cnt <= 0;
    else if (core_cnt < 50) core_cnt <= core_cnt + 1;
  end
  assign o_bus = (core_cnt >= 9) ? incl(i_bus) : (4'hA ^ 4'(core_cnt));
  assign c_o   = incl(c_i);

  int cyc = 0;
  always @(posedge CLOCK) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Offers byte b, returns at #1 into the first cycle with RES_VALID (or after a bound).
  task automatic run(input bit sel, input logic [7:0] b,
                     output int t_res, output int lat, output int nstart, output int ibad);
    int guard;
    guard = 0; nstart = 0; ibad = 0;
    if (sel) begin c_in_data = b; c_in_valid = 1'b1; end
    else     begin in_data   = b; in_valid   = 1'b1; end
    while (!(sel ? c_in_ready : in_ready) && guard < 100) begin
      @(posedge CLOCK); #1; guard++;
    end
    @(posedge CLOCK); #1;
    in_valid = 1'b0; c_in_valid = 1'b0;
    lat = 1;
    while (1) begin
      nstart += int'(sel ? c_start : start);
      if ((sel ? c_i : i_bus) != b) ibad++;
      if ((sel ? c_res_valid : res_valid) || lat >= 100) break;
      @(posedge CLOCK); #1;
      lat++;
    end
    t_res = cyc;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int t_res, t_prev, lat, nstart, ibad, viol, exp_cnt, c_exp, guard;
    logic [7:0]  b, b2;
    logic [11:0] held;

    in_valid = 0; in_data = 0; res_ready = 0;
    c_in_valid = 0; c_in_data = 0; c_res_ready = 1;
    RESET_N = 1'b0;
    #1;
    check("rst_start", start, 0);
    check("rst_i", i_bus, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_busy", busy, 0);
    check("rst_run_count", run_count, 0);
    repeat (2) @(posedge CLOCK);
    #1; RESET_N = 1'b1;
    check("rst_in_ready", in_ready, 1);
    exp_cnt = 0;

    // Single byte 0xA5
    res_ready = 1;
    run(0, 8'hA5, t_res, lat, nstart, ibad);
    check("single_latency", lat, 16);
    check("single_start_cycles", nstart, 2);
    check("single_i_held", ibad, 0);
    check("single_res_data", res_data, exp_res(8'hA5));
    exp_cnt++;
    @(posedge CLOCK); #1;
    check("single_run_count", run_count, 8'(exp_cnt));
    check("single_res_valid_drop", res_valid, 0);

    // Back-pressure with IN_VALID held high
    res_ready = 0;
    b = 8'($urandom);
    run(0, b, t_res, lat, nstart, ibad);
    check("bp_latency", lat, 16);
    check("bp_res_data", res_data, exp_res(b));
    held = res_data;
    b2 = ~b;
    in_data = b2; in_valid = 1;
    viol = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge CLOCK); #1;
      if (res_data !== held || in_ready !== 1'b0 || start !== 1'b0 || res_valid !== 1'b1) viol++;
    end
    check("bp_hold_violations", viol, 0);
    res_ready = 1;
    @(posedge CLOCK); #1;
    exp_cnt++;
    check("bp_ready_after_hs", in_ready, 1);
    check("bp_run_count", run_count, 8'(exp_cnt));
    @(posedge CLOCK); #1;
    in_valid = 0;
    check("bp_next_start", start, 1);
    check("bp_next_i", i_bus, b2);
    guard = 0;
    while (!res_valid && guard < 100) begin @(posedge CLOCK); #1; guard++; end
    check("bp_next_res_data", res_data, exp_res(b2));
    exp_cnt++;
    @(posedge CLOCK); #1;

    // Throughput: 10 random bytes, RES_READY tied high
    t_prev = 0;
    for (int k = 0; k < 10; k++) begin
      b = 8'($urandom);
      run(0, b, t_res, lat, nstart, ibad);
      check($sformatf("tp_data_%0d", k), res_data, exp_res(b));
      if (k > 0) check($sformatf("tp_period_%0d", k), t_res - t_prev, 17);
      t_prev = t_res;
      exp_cnt++;
    end
    @(posedge CLOCK); #1;
    check("tp_run_count", run_count, 8'(exp_cnt));

    // Reset mid-LAUNCH
    in_data = 8'($urandom); in_valid = 1;
    @(posedge CLOCK); #1;
    in_valid = 0;
    check("mid_in_launch", start, 1);
    RESET_N = 1'b0;
    #1;
    check("mid_start_async", start, 0);
    check("mid_busy", busy, 0);
    check("mid_run_count", run_count, 0);
    @(posedge CLOCK); #1;
    RESET_N = 1'b1;
    exp_cnt = 0;
    check("mid_in_ready", in_ready, 1);
    viol = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge CLOCK); #1;
      if (res_valid !== 1'b0 || start !== 1'b0) viol++;
    end
    check("mid_no_result", viol, 0);

    // Parameter corner START_HOLD=1, WAIT_CYCLES=1
    c_exp = 0;
    b = 8'($urandom);
    run(1, b, t_res, lat, nstart, ibad);
    check("c_latency", lat, 4);
    check("c_start_cycles", nstart, 1);
    check("c_res_data", c_res_data, exp_res(b));
    c_exp++;
    t_prev = t_res;
    b = 8'($urandom);
    run(1, b, t_res, lat, nstart, ibad);
    check("c_period", t_res - t_prev, 5);
    check("c_res_data2", c_res_data, exp_res(b));
    c_exp++;

    // Counter wrap: 257 transactions in total
    viol = 0;
    while (c_exp < 257) begin
      b = 8'($urandom);
      run(1, b, t_res, lat, nstart, ibad);
      if (c_res_data !== exp_res(b) || lat != 4) viol++;
      c_exp++;
    end
    check("wrap_data_violations", viol, 0);
    @(posedge CLOCK); #1;
    check("wrap_run_count", c_run_count, 8'(c_exp % 256));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
